// File: rtl/idelay_tap_cal_pkg.sv
// idelay_tap_cal_pkg: shared types and helpers for the IDELAY tap calibrator.
// Optional build macro handled by the users of this package:
// IDELAY_TAP_CAL_ROT_MATCH_EN.
package idelay_tap_cal_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SAMPLE,
        S_STEP,
        S_CTR_LD,
        S_CTR_SETTLE,
        S_CTR_INC,
        S_FINISH
    } state_t;

    localparam logic [7:0] DEFAULT_PATTERN = 8'h5C;
    localparam int         DEFAULT_SETTLE  = 8;

    // Centre of a window.
    // For any window that fits inside the tap range, start + len/2 stays
    // below TAPS, so callers may truncate the result to TW+1 bits.
    function automatic logic [15:0] calc_centre(input logic [15:0] start,
                                                input logic [15:0] len);
        return start + (len >> 1);
    endfunction

endpackage

// File: rtl/idelay_tap_cal_win.sv
// idelay_tap_cal_win: per-tap pass/fail run tracker and best-window registers.
// IDELAY_TAP_CAL_ROT_MATCH_EN adds tracking of the rotation seen at the start
// of each window.
module idelay_tap_cal_win
    import idelay_tap_cal_pkg::*;
#(
    parameter int TW = 5
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
    , parameter int RW = 3
`endif
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          upd_i,
    input  logic [TW-1:0] tap_i,
    input  logic          pass_i,
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
    input  logic [RW-1:0] rot_i,
    output logic [RW-1:0] best_rot_o,
`endif
    output logic [TW-1:0] best_start_o,
    output logic [TW:0]   best_len_o
);

    logic [TW-1:0] cur_start_q, cur_start_d, best_start_q, best_start_d;
    logic [TW:0]   cur_len_q, cur_len_d, best_len_q, best_len_d;
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
    logic [RW-1:0] cur_rot_q, cur_rot_d, best_rot_q, best_rot_d;
`endif

    // Extend or restart the current run.
    // Promote the run to best only when it is strictly longer, so ties keep
    // the earliest window.
    always_comb begin
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
        cur_rot_d    = cur_rot_q;
        best_rot_d   = best_rot_q;
`endif
        if (clr_i) begin
            cur_start_d  = '0;
            cur_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
            cur_rot_d    = '0;
            best_rot_d   = '0;
`endif
        end else if (upd_i) begin
            if (pass_i) begin
                if (cur_len_q == '0 || tap_i == '0) begin
                    cur_start_d = tap_i;
                    cur_len_d   = (TW+1)'(1);
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
                    cur_rot_d   = rot_i;
`endif
                end else begin
                    cur_len_d = cur_len_q + (TW+1)'(1);
                end
            end else begin
                cur_len_d = '0;
            end
            if (cur_len_d > best_len_q) begin
                best_start_d = cur_start_d;
                best_len_d   = cur_len_d;
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
                best_rot_d   = cur_rot_d;
`endif
            end
        end
    end

    // Window state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
            cur_rot_q    <= '0;
            best_rot_q   <= '0;
`endif
        end else begin
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
            cur_rot_q    <= cur_rot_d;
            best_rot_q   <= best_rot_d;
`endif
        end
    end

    assign best_start_o = best_start_q;
    assign best_len_o   = best_len_q;
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
    assign best_rot_o   = best_rot_q;
`endif

endmodule

// File: rtl/idelay_tap_cal.sv
// idelay_tap_cal: sweeps all IDELAY taps against a training word and parks
// the delay line in the centre of the longest passing window.
// IDELAY_TAP_CAL_ROT_MATCH_EN: accept any bit-rotation of the pattern and
// report the rotation on pat_rot_o.
module idelay_tap_cal
    import idelay_tap_cal_pkg::*;
#(
    parameter int            TAPS    = 32,
    parameter int            TW      = 5,
    parameter int            DW      = 8,
    parameter logic [DW-1:0] PATTERN = DW'(DEFAULT_PATTERN),
    parameter int            SETTLE  = DEFAULT_SETTLE,
    parameter int            SAMPLES = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [DW-1:0] rx_data_i,
    output logic          idelay_ce_o,
    output logic          idelay_inc_o,
    output logic          idelay_ld_o,
    output logic [TW-1:0] tap_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o,
    output logic [TW:0]   eye_width_o
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
    , output logic [$clog2(DW)-1:0] pat_rot_o
`endif
);

    localparam int CW = 16;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tap_q, tap_d;
    logic          pass_q, pass_d;
    logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [TW:0]   eye_q, eye_d;
    logic          match, win_clr, win_upd;
    logic [TW-1:0] best_start;
    logic [TW:0]   best_len, centre;

`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
    localparam int RW = $clog2(DW);
    localparam logic [2*DW-1:0] PAT2 = {PATTERN, PATTERN};
    logic [RW-1:0] rot_now, rot_in, best_rot;
    logic [RW-1:0] first_rot_q, first_rot_d, pat_rot_q, pat_rot_d;

    // Match any rotation of the pattern; the lowest matching rotation wins.
    always_comb begin
        match   = 1'b0;
        rot_now = '0;
        for (int r = DW-1; r >= 0; r--) begin
            if (rx_data_i == PAT2[2*DW-1-r -: DW]) begin
                match   = 1'b1;
                rot_now = RW'(r);
            end
        end
    end

    // The rotation reported for a tap is the one seen on its first sample.
    assign rot_in = (cnt_q == '0) ? rot_now : first_rot_q;
`else
    assign match = (rx_data_i == PATTERN);
`endif

    idelay_tap_cal_win #(
        .TW(TW)
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
        , .RW(RW)
`endif
    ) u_win (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (win_clr),
        .upd_i       (win_upd),
        .tap_i       (tap_q),
        .pass_i      (pass_q & match),
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
        .rot_i       (rot_in),
        .best_rot_o  (best_rot),
`endif
        .best_start_o(best_start),
        .best_len_o  (best_len)
    );

    // With no passing tap, best_start and best_len are both 0, so the target
    // centre is tap 0 without needing a special case.
    assign centre = (TW+1)'(calc_centre(16'(best_start), 16'(best_len)));

    // Sequence the sweep and centring.
    // The counter is shared by the settle and sample phases and is always
    // left at 0 on exit from either phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tap_d   = tap_q;
        pass_d  = pass_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
        eye_d   = eye_q;
        win_clr = 1'b0;
        win_upd = 1'b0;
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
        first_rot_d = first_rot_q;
        pat_rot_d   = pat_rot_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    eye_d   = '0;
                    win_clr = 1'b1;
                end
            end
            S_LOAD: begin
                tap_d   = '0;
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CW'(SETTLE-1)) begin
                    cnt_d   = '0;
                    pass_d  = 1'b1;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SAMPLE: begin
                pass_d = pass_q & match;
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
                if (cnt_q == '0) first_rot_d = rot_now;
`endif
                if (cnt_q == CW'(SAMPLES-1)) begin
                    win_upd = 1'b1;
                    cnt_d   = '0;
                    state_d = (tap_q == TW'(TAPS-1)) ? S_CTR_LD : S_STEP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STEP: begin
                tap_d   = tap_q + TW'(1);
                state_d = S_SETTLE;
            end
            S_CTR_LD: begin
                tap_d   = '0;
                cnt_d   = '0;
                state_d = S_CTR_SETTLE;
            end
            S_CTR_SETTLE: begin
                if (cnt_q == CW'(SETTLE-1)) begin
                    cnt_d   = '0;
                    state_d = ({1'b0, tap_q} == centre) ? S_FINISH : S_CTR_INC;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CTR_INC: begin
                tap_d   = tap_q + TW'(1);
                state_d = S_CTR_SETTLE;
            end
            S_FINISH: begin
                done_d  = 1'b1;
                error_d = (best_len == '0);
                eye_d   = best_len;
                busy_d  = 1'b0;
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
                pat_rot_d = best_rot;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tap_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            eye_q   <= '0;
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
            first_rot_q <= '0;
            pat_rot_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tap_q   <= tap_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            eye_q   <= eye_d;
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
            first_rot_q <= first_rot_d;
            pat_rot_q   <= pat_rot_d;
`endif
        end
    end

    // Delay-line strobes are decoded from state.
    // They drop together with the state on reset, and CE and LD can never
    // coincide.
    assign idelay_ld_o  = (state_q == S_LOAD) || (state_q == S_CTR_LD);
    assign idelay_ce_o  = (state_q == S_STEP) || (state_q == S_CTR_INC);
    assign idelay_inc_o = idelay_ce_o;
    assign tap_o        = tap_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign eye_width_o  = eye_q;
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
    assign pat_rot_o    = pat_rot_q;
`endif

endmodule

// File: tb/tb_idelay_tap_cal.sv
// tb_idelay_tap_cal: table-driven and randomized checks of idelay_tap_cal
// against a delay-line model and a window reference model.
// Follows IDELAY_TAP_CAL_ROT_MATCH_EN when it is defined.
module tb_idelay_tap_cal;

    localparam int TAPS = 32, TW = 5, DW = 8, SETTLE = 8, SAMPLES = 16;
    localparam logic [7:0] PAT = 8'h5C;
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          ce, inc, ld, busy, done, error;
    logic [TW-1:0] tap;
    logic [TW:0]   eye;
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
    logic [2:0]    pat_rot;
`endif

    always #5 clk = ~clk;

    idelay_tap_cal #(
        .TAPS(TAPS), .TW(TW), .DW(DW), .PATTERN(PAT),
        .SETTLE(SETTLE), .SAMPLES(SAMPLES)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .rx_data_i   (rx_data),
        .idelay_ce_o (ce),
        .idelay_inc_o(inc),
        .idelay_ld_o (ld),
        .tap_o       (tap),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error),
        .eye_width_o (eye)
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
        , .pat_rot_o (pat_rot)
`endif
    );

    int checks = 0, failures = 0;

    // Stimulus maps per tap: passes, glitches once per 16 cycles, and the
    // rotation of the training word that is presented.
    bit pass_map[TAPS];
    bit glitch_map[TAPS];
    int rot_map[TAPS];

    int m_tap = 0, cyc = 0, n_ce = 0, n_ld = 0, viol = 0, since_ce = 1000;

    function automatic logic [7:0] rotl(input logic [7:0] p, input int r);
        logic [15:0] w;
        w = {8'h00, p} << r;
        return w[7:0] | w[15:8];
    endfunction

    function automatic bit is_rot(input logic [7:0] w);
        for (int r = 0; r < 8; r++)
            if (w == rotl(PAT, r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] bad_word();
        logic [7:0] w;
        do w = 8'($urandom); while (is_rot(w));
        return w;
    endfunction

    // Delay-line model and receive-word source, plus protocol watchdogs.
    always @(negedge clk) begin
        cyc++;
        if (ce && ld) viol++;
        if (inc != ce) viol++;
        if (ce) begin
            if (since_ce < SETTLE) viol++;
            since_ce = 0;
            n_ce++;
        end else begin
            since_ce++;
        end
        if (ld) begin
            n_ld++;
            m_tap = 0;
        end else if (ce && inc && m_tap < TAPS-1) begin
            m_tap = m_tap + 1;
        end
        if (pass_map[m_tap] && !(glitch_map[m_tap] && (cyc % 16) == 7))
            rx_data = rotl(PAT, rot_map[m_tap]);
        else
            rx_data = bad_word();
    end

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Reference: scan every maximal passing run and keep the first longest.
    task automatic model(output int e_tap, output int e_eye, output int e_err,
                         output int e_rot);
        bit ok[TAPS];
        int bs = 0, bl = 0;
        for (int t = 0; t < TAPS; t++)
            ok[t] = pass_map[t] && !glitch_map[t] && (ROT_EN || rot_map[t] == 0);
        for (int s = 0; s < TAPS; s++) begin
            if (ok[s] && (s == 0 || !ok[s-1])) begin
                int len = 0;
                while (s + len < TAPS && ok[s+len]) len++;
                if (len > bl) begin bs = s; bl = len; end
            end
        end
        e_err = (bl == 0);
        e_eye = bl;
        e_tap = bs + bl / 2;
        e_rot = (bl == 0) ? 0 : rot_map[bs];
    endtask

    task automatic run_cal(input string nm, input int e_tap, input int e_eye,
                           input int e_err, input int e_rot);
        int ce0, ld0, v0, to;
        ce0 = n_ce; ld0 = n_ld; v0 = viol;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({nm, ".ld_first"}, int'(ld), 1);
        chk({nm, ".busy_on"}, int'(busy), 1);
        chk({nm, ".done_clr"}, int'(done), 0);
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        to = 0;
        while (!done && to < 4000) begin @(negedge clk); to++; end
        chk({nm, ".timeout"}, int'(done), 1);
        chk({nm, ".tap"}, int'(tap), e_tap);
        chk({nm, ".model_tap"}, m_tap, e_tap);
        chk({nm, ".eye"}, int'(eye), e_eye);
        chk({nm, ".error"}, int'(error), e_err);
        chk({nm, ".busy_off"}, int'(busy), 0);
        chk({nm, ".ce_count"}, n_ce - ce0, TAPS - 1 + e_tap);
        chk({nm, ".ld_count"}, n_ld - ld0, 2);
        chk({nm, ".protocol"}, viol - v0, 0);
`ifdef IDELAY_TAP_CAL_ROT_MATCH_EN
        chk({nm, ".pat_rot"}, int'(pat_rot), e_rot);
`else
        if (e_rot < 0) $display("unexpected negative rotation");
`endif
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] pm;
        logic [31:0] gm;
        int          rot;
        int          e_tap;
        int          e_eye;
        int          e_err;
        int          e_rot;
    } vec_t;

    vec_t vt[7];

    task automatic load_row(input int i);
        for (int t = 0; t < TAPS; t++) begin
            pass_map[t]   = vt[i].pm[t];
            glitch_map[t] = vt[i].gm[t];
            rot_map[t]    = vt[i].rot;
        end
    endtask

    initial begin
        int e_tap, e_eye, e_err, e_rot, to;
        vt[0] = '{32'h0003FC00, 32'h0, 0, 14, 8, 0, 0};
        vt[1] = '{32'h00F0003C, 32'h0, 0, 4, 4, 0, 0};
        vt[2] = '{32'hF0000000, 32'h0, 0, 30, 4, 0, 0};
        vt[3] = '{32'h00000000, 32'h0, 0, 0, 0, 1, 0};
        vt[4] = '{32'h00000FF0, 32'h0, 3, ROT_EN ? 8 : 0, ROT_EN ? 8 : 0,
                  ROT_EN ? 0 : 1, ROT_EN ? 3 : 0};
        vt[5] = '{32'hFFFFFFFF, 32'h00010000, 0, 8, 16, 0, 0};
        vt[6] = '{32'hFFFFFFFF, 32'h0, 0, 16, 32, 0, 0};

        load_row(3);
        repeat (3) @(negedge clk);
        chk("reset.outs", int'({ce, inc, ld, busy, done, error}), 0);
        chk("reset.tap", int'(tap), 0);
        chk("reset.eye", int'(eye), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            load_row(i);
            run_cal($sformatf("vec%0d", i), vt[i].e_tap, vt[i].e_eye,
                    vt[i].e_err, vt[i].e_rot);
        end

        // Reset in the middle of sampling tap 9.
        load_row(0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        to = 0;
        while (tap != 5'd9 && to < 2000) begin @(negedge clk); to++; end
        chk("midrst.reach_tap9", int'(tap), 9);
        repeat (SETTLE + 3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst.outs", int'({ce, inc, ld, busy, done, error}), 0);
        chk("midrst.tap", int'(tap), 0);
        chk("midrst.eye", int'(eye), 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        run_cal("midrst.rerun", 14, 8, 0, 0);

        // Randomized tap maps checked against the reference model.
        for (int k = 0; k < 8; k++) begin
            for (int t = 0; t < TAPS; t++) begin
                pass_map[t]   = ($urandom % 100) < 65;
                glitch_map[t] = ($urandom % 100) < 8;
                rot_map[t]    = ($urandom % 4 == 0) ? int'($urandom % 8) : 0;
            end
            model(e_tap, e_eye, e_err, e_rot);
            run_cal($sformatf("rand%0d", k), e_tap, e_eye, e_err, e_rot);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
